// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Definitions shared by the PWM generator and the PWM capture
//               blocks. These are the speed-code width, the default counter
//               width and the capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Width of the speed code carried by the PWM duty cycle.
    localparam int SPEED_W       = 3;

    // Default width of the period/high-time counters.
    localparam int CNT_W_DEFAULT = 16;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        DIV     = 2'd3
    } pwm_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_if
// Description : Control and result bundle of the PWM capture block.
//               master : drives enable/pwm_in and observes the results.
//               slave  : the capture block itself.
// Signals     : enable, pwm_in               (master -> slave)
//               period_cnt, high_cnt         (slave -> master, CNT_W bits)
//               speed_code                   (slave -> master, SPEED_W bits)
//               valid, stuck_hi, stuck_lo,
//               overrun                      (slave -> master, 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic               enable;
    logic               pwm_in;
    logic [CNT_W-1:0]   period_cnt;
    logic [CNT_W-1:0]   high_cnt;
    logic [SPEED_W-1:0] speed_code;
    logic               valid;
    logic               stuck_hi;
    logic               stuck_lo;
    logic               overrun;

    modport master (
        output enable,
        output pwm_in,
        input  period_cnt,
        input  high_cnt,
        input  speed_code,
        input  valid,
        input  stuck_hi,
        input  stuck_lo,
        input  overrun
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output period_cnt,
        output high_cnt,
        output speed_code,
        output valid,
        output stuck_hi,
        output stuck_lo,
        output overrun
    );

endinterface
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sync_edge
// Description : Multi-flop synchronizer for an asynchronous pin, plus a
//               one-cycle delayed copy used for edge detection.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               in_i    - asynchronous input pin
//               s_o     - synchronized level
//               rise_o  - s_o high this cycle, low the previous cycle
//               fall_o  - s_o low this cycle, high the previous cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic in_i,
    output logic      s_o,
    output logic      rise_o,
    output logic      fall_o
);

    // Fewer than two stages gives no metastability protection, so clamp.
    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_STAGES-1:0] sync_q;
    logic                s_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[c_STAGES-2:0], in_i};
            s_d_q  <= sync_q[c_STAGES-1];
        end
    end

    assign s_o    = sync_q[c_STAGES-1];
    assign rise_o = s_o & ~s_d_q;
    assign fall_o = ~s_o & s_d_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures the period and high time of an external PWM
//               waveform in clk cycles. It recovers the speed code as
//               floor(8*high/period) with a 3-cycle restoring divider, and
//               flags stuck-high and stuck-low inputs and dropped measurements.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               cap    - pwm_capture_if.slave (enable, pwm_in in;
//                        period_cnt, high_cnt, speed_code, valid,
//                        stuck_hi, stuck_lo, overrun out)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pwm_capture_if.slave  cap
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_PRE = c_CNT_MAX - 1'b1;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic s_w;
    logic rise_w;
    logic fall_unused;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (cap.pwm_in),
        .s_o    (s_w),
        .rise_o (rise_w),
        .fall_o (fall_unused)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pwm_state_e         state_q;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   hi_q, hi_d;
    logic [CNT_W-1:0]   p_snap_q;
    logic [CNT_W-1:0]   h_snap_q;
    logic [CNT_W:0]     rem_q;
    logic [SPEED_W-1:0] quot_q;
    logic [1:0]         step_q;

    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   high_q;
    logic [SPEED_W-1:0] speed_q;
    logic               valid_q;
    logic               stuck_hi_q;
    logic               stuck_lo_q;
    logic               overrun_q;

    // ------------------------------------------------------------------
    // Counter next-state: cleared in IDLE, reloaded to 1 on a rise (the
    // rise cycle is itself a high cycle), else saturating increment.
    // ------------------------------------------------------------------
    always_comb begin
        per_d = per_q;
        hi_d  = hi_q;
        if (!cap.enable || state_q == IDLE) begin
            per_d = '0;
            hi_d  = '0;
        end else if (rise_w) begin
            per_d = {{(CNT_W-1){1'b0}}, 1'b1};
            hi_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            if (per_q != c_CNT_MAX) begin
                per_d = per_q + 1'b1;
            end
            if (s_w && hi_q != c_CNT_MAX) begin
                hi_d = hi_q + 1'b1;
            end
        end
    end

    // A timeout fires on the cycle the period counter steps onto its
    // saturation value. Once saturated it cannot step onto it again, so
    // the ARMED state reached after a timeout does not report twice.
    logic timeout_w;
    assign timeout_w = (per_q == c_CNT_PRE) && !rise_w;

    // One restoring-division step. The remainder is always below the
    // divisor, so the shifted value fits in CNT_W+1 bits.
    logic [CNT_W:0]     rem_shift_w;
    logic               rem_ge_w;
    logic [CNT_W:0]     rem_next_w;
    logic [SPEED_W-1:0] quot_next_w;

    assign rem_shift_w = rem_q << 1;
    assign rem_ge_w    = rem_shift_w >= {1'b0, p_snap_q};
    assign rem_next_w  = rem_ge_w ? (rem_shift_w - {1'b0, p_snap_q}) : rem_shift_w;
    assign quot_next_w = {quot_q[SPEED_W-2:0], rem_ge_w};

    // ------------------------------------------------------------------
    // Capture FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            per_q      <= '0;
            hi_q       <= '0;
            p_snap_q   <= '0;
            h_snap_q   <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            step_q     <= 2'd0;
            period_q   <= '0;
            high_q     <= '0;
            speed_q    <= '0;
            valid_q    <= 1'b0;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            per_q   <= per_d;
            hi_q    <= hi_d;
            valid_q <= 1'b0;

            if (!cap.enable) begin
                // Dropping enable aborts any division in flight.
                state_q    <= IDLE;
                stuck_hi_q <= 1'b0;
                stuck_lo_q <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARMED;
                    end

                    ARMED: begin
                        if (rise_w) begin
                            state_q <= MEASURE;
                        end else if (timeout_w) begin
                            stuck_hi_q <= s_w;
                            stuck_lo_q <= ~s_w;
                            speed_q    <= {SPEED_W{s_w}};
                            period_q   <= '0;
                            high_q     <= '0;
                            valid_q    <= 1'b1;
                        end
                    end

                    MEASURE: begin
                        if (rise_w) begin
                            p_snap_q <= per_q;
                            h_snap_q <= hi_q;
                            rem_q    <= {1'b0, hi_q};
                            quot_q   <= '0;
                            step_q   <= 2'd0;
                            state_q  <= DIV;
                        end else if (timeout_w) begin
                            stuck_hi_q <= s_w;
                            stuck_lo_q <= ~s_w;
                            speed_q    <= {SPEED_W{s_w}};
                            period_q   <= '0;
                            high_q     <= '0;
                            valid_q    <= 1'b1;
                            state_q    <= ARMED;
                        end
                    end

                    DIV: begin
                        // A rise here means the period is too short to
                        // be divided; the counters still restart from it.
                        if (rise_w) begin
                            overrun_q <= 1'b1;
                        end
                        rem_q  <= rem_next_w;
                        quot_q <= quot_next_w;
                        step_q <= step_q + 2'd1;
                        if (step_q == 2'd2) begin
                            period_q   <= p_snap_q;
                            high_q     <= h_snap_q;
                            speed_q    <= quot_next_w;
                            valid_q    <= 1'b1;
                            stuck_hi_q <= 1'b0;
                            stuck_lo_q <= 1'b0;
                            state_q    <= MEASURE;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cap.period_cnt = period_q;
    assign cap.high_cnt   = high_q;
    assign cap.speed_code = speed_q;
    assign cap.valid      = valid_q;
    assign cap.stuck_hi   = stuck_hi_q;
    assign cap.stuck_lo   = stuck_lo_q;
    assign cap.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of PWM_module.
- Samples an external PWM waveform, measures the period and high time of each cycle in clk cycles, and recovers the 3-bit speed code as floor(8*high/period).
- Sits on the tt_um top next to PWM_module. Input comes from a uio pin, so PWM_module's output can be looped back for self-test.

Parameters:
- CNT_W, 16, width of the period/high counters; counters saturate at 2^CNT_W-1, which is the timeout.
- SYNC_STAGES, 2, number of flops in the input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  capture enable; low = synchronous clear to IDLE
- pwm_in  input  1  asynchronous PWM input
- period_cnt  output  CNT_W  last measured period, in clk cycles
- high_cnt  output  CNT_W  last measured high time, in clk cycles
- speed_code  output  3  recovered code floor(8*high/period)
- valid  output  1  one-cycle pulse when outputs update
- stuck_hi  output  1  level; input held high for 2^CNT_W-1 cycles
- stuck_lo  output  1  level; input held low for 2^CNT_W-1 cycles
- overrun  output  1  sticky; a measurement was dropped

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counters 0, synchronizer flops 0.
- Input conditioning:
  - s = pwm_in after SYNC_STAGES flops; s_d = s delayed one cycle.
  - rise = s & ~s_d. All timing below is relative to s.
- FSM states: IDLE, ARMED, MEASURE, DIV.
  - IDLE: entered on reset or when enable=0. Outputs hold, except overrun, stuck_hi and stuck_lo, which clear while enable=0. Moves to ARMED when enable=1.
  - ARMED: waits for the first rise. On rise: per_ctr<=1, hi_ctr<=1, go to MEASURE. No measurement is produced from the first rise.
- Counters in MEASURE and DIV:
  - On the rise cycle: per_ctr<=1, hi_ctr<=1.
  - Other cycles: per_ctr<=per_ctr+1 and hi_ctr<=hi_ctr+s, both saturating.
- Measurement on rise in MEASURE:
  - Snapshot P=per_ctr and H=hi_ctr; go to DIV.
  - H<P is guaranteed, because the rise is preceded by at least one low cycle.
- DIV: 3-cycle restoring division.
  - rem starts at H and is CNT_W+1 bits wide.
  - Each cycle: rem<<=1; if rem>=P then the quotient bit is 1 and rem-=P (MSB first).
  - After the 3rd cycle, register period_cnt=P, high_cnt=H, speed_code=quotient and pulse valid, then return to MEASURE.
  - Latency: valid is high 4 cycles after the rise cycle.
- Rise during DIV (period < 4 cycles):
  - Counters reload as normal.
  - That measurement is discarded and overrun is set.
  - The division in progress completes.
- Timeout: per_ctr reaching 2^CNT_W-1 in MEASURE.
  - If s=1: stuck_hi=1, speed_code=7. If s=0: stuck_lo=1, speed_code=0.
  - period_cnt=high_cnt=0, one valid pulse, go to ARMED.
  - stuck_* clears on the next valid measurement.
- Timeout in ARMED (no edge after enable): same flags and pulse, once; stays in ARMED.
- enable falling mid-DIV: the division is aborted and no valid is produced.
- rst_n asserted mid-operation: immediate clear to reset values.
- Invariants: valid is never asserted two consecutive cycles; speed_code is always in 0..7.

Decomposition:
- pwm_pkg: shared with PWM_module. Holds SPEED_W=3, the default CNT_W, and the state enum typedef {IDLE, ARMED, MEASURE, DIV}.
- Sub-module pwm_sync_edge: SYNC_STAGES synchronizer plus s_d register. Outputs s, rise and fall; reusable by other pin-sampling blocks.

Test Plan:
- Reset/idle: rst_n=0 with pwm_in toggling -> all outputs 0, no valid; release with enable=0 -> still no valid.
- Basic duty: enable=1, period 16, high 4, repeated 4 times -> first valid after the 2nd rise, with period_cnt=16, high_cnt=4, speed_code=2, each valid exactly 4 cycles after the synchronized rise. 50% duty -> speed_code=4. High 15 of 16 -> speed_code=7.
- Loopback: PWM_module driven with speed 0..7, output fed to pwm_in -> speed_code equals the driven speed on every valid after the first.
- Stuck levels (CNT_W=8): pwm_in held high after a rise -> after 255 cycles stuck_hi=1, speed_code=7, single valid pulse. Held low -> stuck_lo=1, speed_code=0. Then resume 16/8 PWM -> flags clear, speed_code=4.
- Overrun: period 3 (high 1) -> overrun=1 and held; enable low for 1 cycle -> overrun=0.
- Mid-operation: enable=0 during DIV -> no valid. rst_n pulsed mid-MEASURE -> outputs 0 immediately (asynchronously); next measurement only after two fresh rises.
